multimode_counter: RTL and testbench
====================================

Name: multimode_counter

Overview:
- Parametrised, runtime-configurable successor to the basic pixel/line up-counter used across the edge-detection pipeline.
- Adds:
  - up/down direction;
  - runtime min/max bounds;
  - parallel load;
  - wrap or saturate mode;
  - a boundary-event pulse and a sticky overflow flag.
- Used for window addressing, line-buffer pointers and frame/line position tracking. Multiple instances are cascaded via the event pulse.

Parameters:
- WIDTH, 10, count width in bits (1..32).
- STEP, 1, magnitude added/subtracted per enabled cycle (1..2**WIDTH-1).
- SATURATE, 0, 0 = wrap at bounds, 1 = clamp at bounds.
- RESET_VALUE, 0, count value after reset (WIDTH bits, truncated).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance count by STEP this cycle.
- up_down  input  1  1 = count up, 0 = count down; sampled on enabled cycles.
- load  input  1  load load_value this cycle.
- load_value  input  WIDTH  value for parallel load.
- min_value  input  WIDTH  lower bound (inclusive), runtime.
- max_value  input  WIDTH  upper bound (inclusive), runtime.
- clear_sticky  input  1  clears overflow_sticky.
- count  output  WIDTH  registered count value.
- at_limit  output  1  combinational: (up_down && count==max_value) || (!up_down && count==min_value).
- event_pulse  output  1  registered; high for one cycle after a wrap or clamp occurred.
- overflow_sticky  output  1  registered; set on any wrap or clamp.
- config_error  output  1  combinational: min_value > max_value.

Behaviour:
- Reset values (reset high at a rising edge): count=RESET_VALUE, event_pulse=0, overflow_sticky=0.
- Priority each edge: reset > load > enable > hold.
- Load:
  - count <= load_value on the next edge, with no bound check; out-of-range values are accepted.
  - event_pulse=0 in a load cycle.
  - Load overrides enable in the same cycle.
- Config error: while config_error=1 and enable=1 and load=0, count holds and event_pulse=0. Load and reset still work.
- Up step (enable=1, up_down=1):
  - Compute nxt = count + STEP in WIDTH+1 bits.
  - If nxt > max_value (unsigned, WIDTH+1-bit compare), a boundary event occurs:
    - SATURATE=0: count <= min_value.
    - SATURATE=1: count <= max_value.
  - Otherwise count <= nxt[WIDTH-1:0].
  - A count already above max_value (after a load) therefore produces an event on the next step.
- Down step (enable=1, up_down=0):
  - Compute nxt = count - STEP in WIDTH+1 bits with borrow.
  - If a borrow occurs or nxt < min_value, a boundary event occurs:
    - SATURATE=0: count <= max_value.
    - SATURATE=1: count <= min_value.
  - Otherwise count <= nxt[WIDTH-1:0].
- Overshoot rule: wrap is to the bound, not modulo. With STEP>1, any overshoot lands exactly on min (up) or max (down).
- Saturate mode: each enabled step taken at the limit is a boundary event. event_pulse stays high on consecutive clamped cycles.
- event_pulse: registered version of the boundary event. It is valid in the same cycle the new count appears (one-cycle latency from the enabled edge). It is 0 on cycles with no event.
- overflow_sticky:
  - Set on the edge where a boundary event occurs.
  - clear_sticky=1 clears it on the next edge.
  - If an event and clear_sticky=1 occur in the same cycle, set wins.
- Bounds are sampled every cycle. Changing min/max mid-count takes effect at the next enabled step, with no reset of count.
- Reset mid-count: count returns to RESET_VALUE on the next edge regardless of load, enable or bounds.
- WIDTH=1, STEP=1, min=0, max=1, wrap mode: behaves as a toggle flip-flop.

Test Plan:
- Reset, then enable=1, up, WIDTH=4, STEP=1, min=0, max=9, wrap:
  - count steps 0,1,…,9,0.
  - event_pulse is high exactly in the cycle count shows 0 after 9.
  - at_limit is high while count=9.
- Up with STEP=3, min=2, max=10, load 2:
  - count goes 2,5,8,2 (overshoot 11>10 wraps to min).
  - overflow_sticky is set after the wrap; clear_sticky=1 clears it the next cycle.
- Down with SATURATE=1, min=0, max=15, load 2, STEP=1:
  - count goes 2,1,0,0,0.
  - event_pulse is high on both clamped cycles.
  - The 8-bit instance (WIDTH=8) with load 0 and STEP=5 clamps to 0 via the borrow path.
- Simultaneous load=1, enable=1, load_value=7 → count=7 next cycle, event_pulse=0.
- Simultaneous reset=1, load=1 → count=RESET_VALUE.
- Set min=12, max=4 with enable=1 → config_error=1 and count holds. Restoring min=0 resumes stepping.
- Load 14 with max=9, up, wrap → next enabled step gives count=min_value (0) and event_pulse=1.
- Assert reset mid-sequence → count=0, event_pulse=0, overflow_sticky=0 on the next edge.

Source files
------------

// File: rtl/multimode_counter_if.sv
// multimode_counter_if: control, bound and status signals of one multimode_counter
interface multimode_counter_if #(
  parameter int WIDTH = 10
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] min_value;
  logic [WIDTH-1:0] max_value;
  logic             clear_sticky;
  logic [WIDTH-1:0] count;
  logic             at_limit;
  logic             event_pulse;
  logic             overflow_sticky;
  logic             config_error;
  modport master (
    output enable, up_down, load, load_value, min_value, max_value, clear_sticky,
    input  count, at_limit, event_pulse, overflow_sticky, config_error
  );
  modport slave (
    input  enable, up_down, load, load_value, min_value, max_value, clear_sticky,
    output count, at_limit, event_pulse, overflow_sticky, config_error
  );
endinterface

// File: rtl/multimode_counter.sv
// multimode_counter: bounded up/down counter with load, wrap/saturate, event pulse and sticky overflow
module multimode_counter #(
  parameter int              WIDTH       = 10,
  parameter longint unsigned STEP        = 1,
  parameter bit              SATURATE    = 1'b0,
  parameter longint unsigned RESET_VALUE = 0
) (
  input logic                clock,
  input logic                reset,
  multimode_counter_if.slave bus
);
  localparam logic [WIDTH:0]   step_w    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] reset_val = WIDTH'(RESET_VALUE);
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH:0]   nxt_up, nxt_dn;
  logic             up_evt, dn_evt, cfg_err, step, evt;
  logic             event_q, sticky_q;
  // One extra bit catches carry on the way up and borrow on the way down
  always_comb begin
    nxt_up    = {1'b0, count_q} + step_w;
    nxt_dn    = {1'b0, count_q} - step_w;
    up_evt    = nxt_up > {1'b0, bus.max_value};
    dn_evt    = nxt_dn[WIDTH] || (nxt_dn[WIDTH-1:0] < bus.min_value);
    cfg_err   = bus.min_value > bus.max_value;
    step      = bus.enable && !bus.load && !cfg_err;
    evt       = step && (bus.up_down ? up_evt : dn_evt);
    count_nxt = bus.up_down
      ? (up_evt ? (SATURATE ? bus.max_value : bus.min_value) : nxt_up[WIDTH-1:0])
      : (dn_evt ? (SATURATE ? bus.min_value : bus.max_value) : nxt_dn[WIDTH-1:0]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= reset_val;
      event_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= bus.load ? bus.load_value : step ? count_nxt : count_q;
      event_q  <= evt;
      sticky_q <= evt || (sticky_q && !bus.clear_sticky);
    end
  end
  assign bus.count           = count_q;
  assign bus.event_pulse     = event_q;
  assign bus.overflow_sticky = sticky_q;
  assign bus.config_error    = cfg_err;
  assign bus.at_limit        = bus.up_down ? (count_q == bus.max_value) : (count_q == bus.min_value);
endmodule

// File: tb/tb_multimode_counter.sv
// tb_multimode_counter: directed checks of wrap, saturate, load, bounds and reset behaviour
module tb_multimode_counter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clock = ~clock;
  multimode_counter_if #(.WIDTH(4)) a_if ();
  multimode_counter_if #(.WIDTH(4)) b_if ();
  multimode_counter_if #(.WIDTH(4)) c_if ();
  multimode_counter_if #(.WIDTH(8)) d_if ();
  multimode_counter #(.WIDTH(4), .STEP(1), .SATURATE(1'b0), .RESET_VALUE(0))
    u_a (.clock(clock), .reset(reset), .bus(a_if));
  multimode_counter #(.WIDTH(4), .STEP(3), .SATURATE(1'b0), .RESET_VALUE(0))
    u_b (.clock(clock), .reset(reset), .bus(b_if));
  multimode_counter #(.WIDTH(4), .STEP(1), .SATURATE(1'b1), .RESET_VALUE(0))
    u_c (.clock(clock), .reset(reset), .bus(c_if));
  multimode_counter #(.WIDTH(8), .STEP(5), .SATURATE(1'b1), .RESET_VALUE(200))
    u_d (.clock(clock), .reset(reset), .bus(d_if));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    {a_if.enable, a_if.up_down, a_if.load, a_if.clear_sticky} = '0;
    {b_if.enable, b_if.up_down, b_if.load, b_if.clear_sticky} = '0;
    {c_if.enable, c_if.up_down, c_if.load, c_if.clear_sticky} = '0;
    {d_if.enable, d_if.up_down, d_if.load, d_if.clear_sticky} = '0;
    {a_if.load_value, a_if.min_value, a_if.max_value} = '0;
    {b_if.load_value, b_if.min_value, b_if.max_value} = '0;
    {c_if.load_value, c_if.min_value, c_if.max_value} = '0;
    {d_if.load_value, d_if.min_value, d_if.max_value} = '0;
    tick();
    chk("rst_count", a_if.count, 0);
    chk("rst_event", a_if.event_pulse, 0);
    chk("rst_sticky", a_if.overflow_sticky, 0);
    chk("rst_value_d", d_if.count, 200);
    reset = 1'b0;
    // Decade counter 0..9 then wrap
    a_if.max_value = 9;
    a_if.up_down = 1'b1;
    a_if.enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("dec_count", a_if.count, i % 10);
      chk("dec_event", a_if.event_pulse, i == 10);
      chk("dec_at_limit", a_if.at_limit, i == 9);
    end
    chk("dec_sticky", a_if.overflow_sticky, 1);
    a_if.load = 1'b1;
    a_if.load_value = 7;
    tick();
    chk("load_en_count", a_if.count, 7);
    chk("load_en_event", a_if.event_pulse, 0);
    a_if.load = 1'b0;
    a_if.min_value = 12;
    a_if.max_value = 4;
    #1;
    chk("cfg_err_set", a_if.config_error, 1);
    tick();
    chk("cfg_err_hold", a_if.count, 7);
    chk("cfg_err_event", a_if.event_pulse, 0);
    a_if.min_value = 0;
    a_if.max_value = 9;
    #1;
    chk("cfg_err_clr", a_if.config_error, 0);
    tick();
    chk("cfg_resume", a_if.count, 8);
    a_if.load = 1'b1;
    a_if.load_value = 14;
    tick();
    chk("load_oob", a_if.count, 14);
    a_if.load = 1'b0;
    tick();
    chk("oob_wrap_count", a_if.count, 0);
    chk("oob_wrap_event", a_if.event_pulse, 1);
    a_if.up_down = 1'b0;
    tick();
    chk("dn_wrap_count", a_if.count, 9);
    chk("dn_wrap_event", a_if.event_pulse, 1);
    tick();
    chk("dn_step_count", a_if.count, 8);
    chk("dn_step_event", a_if.event_pulse, 0);
    reset = 1'b1;
    a_if.load = 1'b1;
    a_if.load_value = 5;
    tick();
    chk("mid_rst_count", a_if.count, 0);
    chk("mid_rst_event", a_if.event_pulse, 0);
    chk("mid_rst_sticky", a_if.overflow_sticky, 0);
    reset = 1'b0;
    a_if.load = 1'b0;
    a_if.enable = 1'b0;
    // STEP=3 within [2,10]: overshoot lands on min
    b_if.min_value = 2;
    b_if.max_value = 10;
    b_if.load = 1'b1;
    b_if.load_value = 2;
    tick();
    chk("s3_load", b_if.count, 2);
    b_if.load = 1'b0;
    b_if.up_down = 1'b1;
    b_if.enable = 1'b1;
    tick();
    chk("s3_c5", b_if.count, 5);
    tick();
    chk("s3_c8", b_if.count, 8);
    chk("s3_sticky0", b_if.overflow_sticky, 0);
    b_if.clear_sticky = 1'b1;
    tick();
    chk("s3_wrap", b_if.count, 2);
    chk("s3_event", b_if.event_pulse, 1);
    chk("s3_set_wins", b_if.overflow_sticky, 1);
    b_if.enable = 1'b0;
    tick();
    chk("s3_clear", b_if.overflow_sticky, 0);
    chk("s3_hold", b_if.count, 2);
    chk("s3_event_off", b_if.event_pulse, 0);
    b_if.clear_sticky = 1'b0;
    // Saturating down then up
    c_if.max_value = 15;
    c_if.load = 1'b1;
    c_if.load_value = 2;
    tick();
    c_if.load = 1'b0;
    c_if.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_dn_count", c_if.count, i == 0 ? 1 : 0);
      chk("sat_dn_event", c_if.event_pulse, i >= 2);
    end
    chk("sat_at_limit", c_if.at_limit, 1);
    c_if.load = 1'b1;
    c_if.load_value = 14;
    c_if.up_down = 1'b1;
    tick();
    c_if.load = 1'b0;
    tick();
    chk("sat_up_15", c_if.count, 15);
    chk("sat_up_ev0", c_if.event_pulse, 0);
    tick();
    chk("sat_up_clamp", c_if.count, 15);
    chk("sat_up_ev1", c_if.event_pulse, 1);
    c_if.enable = 1'b0;
    // 8-bit STEP=5 saturating borrow path
    d_if.max_value = 255;
    d_if.load = 1'b1;
    tick();
    chk("w8_load0", d_if.count, 0);
    d_if.load = 1'b0;
    d_if.enable = 1'b1;
    tick();
    chk("w8_borrow", d_if.count, 0);
    chk("w8_borrow_ev", d_if.event_pulse, 1);
    chk("w8_sticky", d_if.overflow_sticky, 1);
    d_if.load = 1'b1;
    d_if.load_value = 7;
    tick();
    chk("w8_load7", d_if.count, 7);
    chk("w8_load_ev", d_if.event_pulse, 0);
    d_if.load = 1'b0;
    tick();
    chk("w8_c2", d_if.count, 2);
    tick();
    chk("w8_clamp", d_if.count, 0);
    chk("w8_clamp_ev", d_if.event_pulse, 1);
    reset = 1'b1;
    d_if.load = 1'b1;
    d_if.load_value = 9;
    tick();
    chk("w8_rst_load", d_if.count, 200);
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
